// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), one full-subtractor bit per clock, LSB first.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH; one op per WIDTH+1 cycles.
// Backpressure: start is only sampled while busy==0 (IDLE or DONE); requests during RUN are dropped.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, br_nxt, accept, last;

    always_comb begin
        d      = sa[0] ^ sb[0] ^ br;
        br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        accept = start && (state != RUN);
        last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // diff is left alone on accept so the previous result stays readable until bits start shifting in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa   <= sa >> 1;
            sb   <= sb >> 1;
            br   <= br_nxt;
            cnt  <= cnt + 1'b1;
            diff <= {d, diff[WIDTH-1:1]};
            if (last) bout <= br_nxt;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
